// File: rtl/sblk_agen_if.sv
// sblk_agen_if: start/abort/config inputs and address/enable outputs of the superblock address sequencer
interface sblk_agen_if #(
    parameter int WBUF_ADDR_LEN    = 10,
    parameter int ACTBUF_ADDRH_LEN = 6,
    parameter int PBUF_ADDR_LEN    = 9
);
    logic                        start;
    logic                        abort;
    logic [PBUF_ADDR_LEN:0]      cfg_n_out;
    logic [ACTBUF_ADDRH_LEN:0]   cfg_n_in;
    logic [WBUF_ADDR_LEN-1:0]    cfg_wbase;
    logic [ACTBUF_ADDRH_LEN-1:0] cfg_abase;
    logic [WBUF_ADDR_LEN-1:0]    wbuf_rd_addr;
    logic [ACTBUF_ADDRH_LEN-1:0] actbuf_rd_addrh;
    logic [PBUF_ADDR_LEN-1:0]    pbuf_rd_addr;
    logic                        issue_vld;
    logic [PBUF_ADDR_LEN-1:0]    pbuf_wr_addr;
    logic                        pbuf_wr_en;
    logic                        busy;
    logic                        done;

    modport master (
        output start, abort, cfg_n_out, cfg_n_in, cfg_wbase, cfg_abase,
        input  wbuf_rd_addr, actbuf_rd_addrh, pbuf_rd_addr, issue_vld,
               pbuf_wr_addr, pbuf_wr_en, busy, done
    );

    modport slave (
        input  start, abort, cfg_n_out, cfg_n_in, cfg_wbase, cfg_abase,
        output wbuf_rd_addr, actbuf_rd_addrh, pbuf_rd_addr, issue_vld,
               pbuf_wr_addr, pbuf_wr_en, busy, done
    );
endinterface

// File: rtl/sblk_agen.sv
// sblk_agen: runs reduction (outer) x partial-sum (inner) loops, issuing buffer read addresses and delayed pbuf writes
module sblk_agen #(
    parameter int WBUF_ADDR_LEN    = 10,
    parameter int ACTBUF_ADDRH_LEN = 6,
    parameter int PBUF_ADDR_LEN    = 9,
    parameter int PIPE_LAT         = 8
) (
    input logic       clk_l,
    input logic       rst_n,
    sblk_agen_if.slave bus
);
    localparam int NW  = PBUF_ADDR_LEN + 1;
    localparam int KW  = ACTBUF_ADDRH_LEN + 1;
    localparam int PLW = $clog2(PIPE_LAT + 1);
    localparam int SW  = NW > PLW ? NW : PLW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                                    st_q, st_d;
    logic [SW-1:0]                             s_q, s_d, row_len;
    logic [KW-1:0]                             k_q, k_d, n_in_q, n_in_d;
    logic [NW-1:0]                             n_out_q, n_out_d;
    logic [WBUF_ADDR_LEN-1:0]                  wbase_q, wbase_d, wbuf_q, wbuf_d;
    logic [ACTBUF_ADDRH_LEN-1:0]               abase_q, abase_d, act_q, act_d;
    logic [PBUF_ADDR_LEN-1:0]                  prd_q, prd_d;
    logic                                      iss_q, iss_d, busy_q, busy_d, done_q, done_d;
    logic [PIPE_LAT-1:0]                       sv_q, sv_d;
    logic [PIPE_LAT-1:0][PBUF_ADDR_LEN-1:0]    sa_q, sa_d;

    // Loop sequencing; outputs are derived from the next state so they are registered yet appear the cycle after start
    always_comb begin
        st_d    = st_q;
        s_d     = s_q;
        k_d     = k_q;
        n_out_d = n_out_q;
        n_in_d  = n_in_q;
        wbase_d = wbase_q;
        abase_d = abase_q;
        // A row always spans at least PIPE_LAT slots so a partial sum is written back before it is read again
        row_len = SW'(n_out_q) > SW'(PIPE_LAT) ? SW'(n_out_q) : SW'(PIPE_LAT);
        if (bus.abort) begin
            st_d = IDLE;
        end else begin
            case (st_q)
                IDLE: if (bus.start) begin
                    n_out_d = bus.cfg_n_out;
                    n_in_d  = bus.cfg_n_in;
                    wbase_d = bus.cfg_wbase;
                    abase_d = bus.cfg_abase;
                    s_d     = '0;
                    k_d     = '0;
                    st_d    = (bus.cfg_n_out == '0 || bus.cfg_n_in == '0) ? DONE : RUN;
                end
                RUN: if (s_q == row_len - SW'(1)) begin
                    s_d = '0;
                    if (k_q == n_in_q - KW'(1)) st_d = DRAIN;
                    else k_d = k_q + KW'(1);
                end else begin
                    s_d = s_q + SW'(1);
                end
                DRAIN: if (s_q == SW'(PIPE_LAT - 1)) st_d = DONE;
                       else s_d = s_q + SW'(1);
                DONE: st_d = IDLE;
            endcase
        end
        iss_d  = st_d == RUN && s_d < SW'(n_out_d);
        prd_d  = iss_d ? PBUF_ADDR_LEN'(s_d) : prd_q;
        act_d  = iss_d ? abase_d + ACTBUF_ADDRH_LEN'(k_d) : act_q;
        wbuf_d = iss_d ? wbase_d + WBUF_ADDR_LEN'(k_d) * WBUF_ADDR_LEN'(n_out_d) + WBUF_ADDR_LEN'(s_d) : wbuf_q;
        busy_d = st_d == RUN || st_d == DRAIN;
        done_d = st_d == DONE;
    end

    // Write-back delay line: carries each issued pbuf read to its write PIPE_LAT cycles later; abort flushes it
    always_comb begin
        sv_d = sv_q;
        sa_d = sa_q;
        if (bus.abort) begin
            sv_d = '0;
            sa_d = '0;
        end else if (st_q == RUN || st_q == DRAIN) begin
            sv_d[0] = iss_q;
            sa_d[0] = prd_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sv_d[i] = sv_q[i-1];
                sa_d[i] = sa_q[i-1];
            end
        end
    end

    // State, latched config, registered outputs and delay line
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            n_out_q <= '0;
            n_in_q  <= '0;
            wbase_q <= '0;
            abase_q <= '0;
            wbuf_q  <= '0;
            act_q   <= '0;
            prd_q   <= '0;
            iss_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sv_q    <= '0;
            sa_q    <= '0;
        end else begin
            st_q    <= st_d;
            s_q     <= s_d;
            k_q     <= k_d;
            n_out_q <= n_out_d;
            n_in_q  <= n_in_d;
            wbase_q <= wbase_d;
            abase_q <= abase_d;
            wbuf_q  <= wbuf_d;
            act_q   <= act_d;
            prd_q   <= prd_d;
            iss_q   <= iss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sv_q    <= sv_d;
            sa_q    <= sa_d;
        end
    end

    assign bus.wbuf_rd_addr    = wbuf_q;
    assign bus.actbuf_rd_addrh = act_q;
    assign bus.pbuf_rd_addr    = prd_q;
    assign bus.issue_vld       = iss_q;
    assign bus.pbuf_wr_en      = sv_q[PIPE_LAT-1];
    assign bus.pbuf_wr_addr    = sa_q[PIPE_LAT-1];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule

// File: doc/sblk_agen.md
# sblk_agen

Address/control sequencer that drives one superblock unit for a single tile pass. It runs the reduction loop (outer) over the output-partial-sum loop (inner) and issues the weight-buffer, activation-buffer and partial-sum-buffer read addresses each clk_l cycle. It also issues the matching partial-sum write address and enable, delayed by the unit's read-to-write pipeline latency. It sits directly upstream of the superblock unit: its outputs connect one-to-one to the unit's address and enable inputs.

## Interface
Parameters:
- WBUF_ADDR_LEN, 10: weight-buffer address width.
- ACTBUF_ADDRH_LEN, 6: activation-buffer high-address width.
- PBUF_ADDR_LEN, 9: partial-sum-buffer address width.
- PIPE_LAT, 8: clk_l cycles from pbuf_rd_addr issue to the matching pbuf write; must be ≥ 1.

Ports:
- clk_l  in  1  low-rate clock; all logic is on this edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- abort  in  1  synchronous abort; wins over every other event.
- cfg_n_out  in  PBUF_ADDR_LEN+1  inner-loop count (partial-sum entries per reduction step).
- cfg_n_in  in  ACTBUF_ADDRH_LEN+1  outer-loop count (reduction steps).
- cfg_wbase  in  WBUF_ADDR_LEN  weight base address.
- cfg_abase  in  ACTBUF_ADDRH_LEN  activation base high-address.
- wbuf_rd_addr  out  WBUF_ADDR_LEN  weight read address.
- actbuf_rd_addrh  out  ACTBUF_ADDRH_LEN  activation read high-address.
- pbuf_rd_addr  out  PBUF_ADDR_LEN  partial-sum read address.
- issue_vld  out  1  the address outputs above carry a real issue this cycle.
- pbuf_wr_addr  out  PBUF_ADDR_LEN  partial-sum write address.
- pbuf_wr_en  out  1  partial-sum write enable.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at normal completion.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - On start, latch all cfg_* inputs and clear k and m.
  - If latched cfg_n_out==0 or cfg_n_in==0, go to DONE. Otherwise go to RUN.
- **RUN**: each cycle is either an issue slot or a bubble.
  - Row length L = max(n_out, PIPE_LAT). Slot index s counts 0..L-1.
  - s < n_out is an issue slot, with m = s:
    - issue_vld = 1.
    - pbuf_rd_addr = m.
    - wbuf_rd_addr = (wbase + k*n_out + m) mod 2^WBUF_ADDR_LEN.
    - actbuf_rd_addrh = (abase + k) mod 2^ACTBUF_ADDRH_LEN.
  - s ≥ n_out is a bubble: issue_vld = 0.
  - Bubbles guarantee that the read of entry m in step k+1 happens no earlier than the write of entry m from step k.
  - At s = L-1, k increments. After the last slot of k = n_in-1, go to DRAIN.
- **Write path**
  - A PIPE_LAT-deep shift register carries {issue_vld, pbuf_rd_addr}. Its output drives pbuf_wr_en and pbuf_wr_addr.
  - It keeps shifting in every state except IDLE and DONE.
- **DRAIN**: hold for PIPE_LAT cycles, then go to DONE.
- **DONE**: done = 1 for exactly one cycle, then go to IDLE.
- **Address outputs when not issuing**: hold their last values. Only issue_vld qualifies them.
- **start** while busy or in DONE is ignored.
- **abort** in any state:
  - Next cycle the state is IDLE.
  - The write shift register is cleared, so no pending write reaches pbuf.
  - done is not pulsed.
- **Counter widths**: k and m are sized to the cfg widths. The wbuf address product is computed at WBUF_ADDR_LEN bits and wraps silently.

## Timing
- Reset values: all outputs 0, state IDLE, shift register cleared.
- Start accepted at edge t → first issue (issue_vld = 1) in cycle t+1.
- First pbuf_wr_en at cycle t+1+PIPE_LAT.
- RUN lasts n_in*L cycles, DRAIN lasts PIPE_LAT cycles, then done in the following cycle.
- Degenerate config (a zero count): done at t+1, with no issues and no writes.
- pbuf_wr_en is high for exactly n_in*n_out cycles per pass.

## Test plan
- **Reset**: assert rst_n low mid-RUN (asynchronously) → all outputs 0 immediately; IDLE after release; no done.
- **No bubbles**: n_out=10, n_in=3, wbase=0, abase=4, PIPE_LAT=8 → 30 issues with no bubbles.
  - wbuf_rd_addr runs 0..29; actbuf_rd_addrh is 4/5/6 per row.
  - Writes mirror the rd addresses 8 cycles later.
  - done at t+1+30+8.
- **Bubbles**: n_out=3, n_in=2, PIPE_LAT=8 → each row is 3 issues then 5 bubbles.
  - For every entry, the step-1 read of entry m falls no earlier than the step-0 write of entry m.
  - 6 writes total; done at t+1+16+8.
- **Wrap**: wbase=1020, n_out=8, n_in=1 → wbuf_rd_addr is 1020..1023, then 0..3.
- **Abort**: abort at the 5th issue of n_out=10, n_in=2 → IDLE next cycle; pbuf_wr_en never goes high afterwards; no done; a new start is accepted.
- **Ignored start / zero config**:
  - start pulsed during RUN → no effect; total issue count unchanged.
  - start with cfg_n_in=0 → done at t+1; issue_vld and pbuf_wr_en stay 0.
